// File: rtl/rf_pkg.sv
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared constants and types for the writeback register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef logic [ADDR_W-1:0]                 reg_addr_t;
    typedef logic [DATA_W-1:0]                 reg_data_t;
    typedef logic [NUM_REGS-1:0][DATA_W-1:0]   reg_array_t;

    localparam reg_addr_t   ZERO_REG     = 3'd0;
    localparam logic [7:0]  WR_COUNT_MAX = 8'd255;
endpackage : rf_pkg

`default_nettype wire

// File: rtl/reg_file_wb_if.sv
// ============================================================================
//  Module      : reg_file_wb_if
//  Description : Write/read bus between writeback/execute and the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_wb_if;
    import rf_pkg::*;

    logic        wr_en;
    reg_addr_t   wr_addr;
    reg_data_t   wr_data;
    reg_addr_t   rd_addr_a;
    reg_addr_t   rd_addr_b;
    reg_data_t   rd_data_a;
    reg_data_t   rd_data_b;
    logic [7:0]  wr_count;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wr_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wr_count
    );
endinterface : reg_file_wb_if

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
//  Module      : rf_read_port
//  Description : One combinational read port: decode, R0 zero-force and the
//                optional same-cycle write forward (RF_WRITE_BYPASS_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_read_port
    import rf_pkg::*;
(
    input  wire logic       rst_n_i,
    input  wire reg_array_t regs_i,
    input  wire reg_addr_t  rd_addr_i,
    input  wire logic       wr_en_i,
    input  wire reg_addr_t  wr_addr_i,
    input  wire reg_data_t  wr_data_i,
    output      reg_data_t  rd_data_o
);

`ifdef RF_WRITE_BYPASS_EN
    logic w_fwd;
    assign w_fwd = rst_n_i && wr_en_i && (wr_addr_i != ZERO_REG) && (rd_addr_i == wr_addr_i);
`else
    logic w_fwd;
    logic w_unused;
    assign w_fwd    = 1'b0;
    assign w_unused = ^{rst_n_i, wr_en_i, wr_addr_i, wr_data_i};
`endif

    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
        if (rd_addr_i == ZERO_REG) begin
            rd_data_o = '0;
        end
        if (w_fwd) begin
            rd_data_o = wr_data_i;
        end
    end

endmodule : rf_read_port

`default_nettype wire

// File: rtl/reg_file_wb.sv
// ============================================================================
//  Module      : reg_file_wb
//  Description : 8x16 writeback register file, R0 hardwired to zero, two
//                combinational read ports, saturating write counter.
//                Optional forward build macro: RF_WRITE_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_wb
    import rf_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    reg_file_wb_if.slave bus
);

    reg_array_t  regs_q, regs_d;
    logic [7:0]  wr_count_q, wr_count_d;
    logic        w_commit;

    assign w_commit = bus.wr_en && (bus.wr_addr != ZERO_REG);

    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (w_commit) begin
            regs_d[bus.wr_addr] = bus.wr_data;
            if (wr_count_q != WR_COUNT_MAX) begin
                wr_count_d = wr_count_q + 8'd1;
            end
        end
    end

    // Reset wins over any write presented on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q     <= '0;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.wr_count = wr_count_q;

    rf_read_port u_port_a (
        .rst_n_i   (rst_n),
        .regs_i    (regs_q),
        .rd_addr_i (bus.rd_addr_a),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .rd_data_o (bus.rd_data_a)
    );

    rf_read_port u_port_b (
        .rst_n_i   (rst_n),
        .regs_i    (regs_q),
        .rd_addr_i (bus.rd_addr_b),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .rd_data_o (bus.rd_data_b)
    );

endmodule : reg_file_wb

`default_nettype wire

// File: tb/tb_reg_file_wb.sv
// ============================================================================
//  Module      : tb_reg_file_wb
//  Description : Directed, table-driven self-checking bench for reg_file_wb.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_wb;
    import rf_pkg::*;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    reg_file_wb_if bus_if ();

    reg_file_wb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        reg_addr_t   wa;
        reg_data_t   wd;
        reg_addr_t   ra;
        reg_addr_t   rb;
        reg_data_t   exp_a;      // stored-value read
        reg_data_t   exp_b;
        reg_data_t   fwd_a;      // read when same-cycle forwarding is built in
        reg_data_t   fwd_b;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input reg_addr_t wa, input reg_data_t wd,
                         input reg_addr_t ra, input reg_addr_t rb);
        bus_if.wr_en     = we;
        bus_if.wr_addr   = wa;
        bus_if.wr_data   = wd;
        bus_if.rd_addr_a = ra;
        bus_if.rd_addr_b = rb;
    endtask

    function automatic vec_t mk(input logic we, input reg_addr_t wa, input reg_data_t wd,
                                input reg_addr_t ra, input reg_addr_t rb,
                                input reg_data_t ea, input reg_data_t eb,
                                input reg_data_t fa, input reg_data_t fb,
                                input logic [7:0] ec);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
        v.exp_a = ea; v.exp_b = eb; v.fwd_a = fa; v.fwd_b = fb; v.exp_cnt = ec;
        return v;
    endfunction

    initial begin
        n_total = 0;
        n_pass  = 0;

        // Expected values are the pre-edge reads in each row's cycle.
        vecs[0] = mk(1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd0);
        vecs[1] = mk(1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 8'd0);
        vecs[2] = mk(1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 8'd1);
        vecs[3] = mk(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd5, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 8'd1);
        vecs[4] = mk(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd1);
        vecs[5] = mk(1'b1, 3'd2, 16'h0011, 3'd2, 3'd5, 16'h0000, 16'h1234, 16'h0011, 16'h1234, 8'd1);
        vecs[6] = mk(1'b1, 3'd2, 16'h0022, 3'd2, 3'd2, 16'h0011, 16'h0011, 16'h0022, 16'h0022, 8'd2);
        vecs[7] = mk(1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, 16'h0022, 16'h1234, 16'h0022, 16'h1234, 8'd3);
        vecs[8] = mk(1'b1, 3'd7, 16'hA5C3, 3'd7, 3'd6, 16'h0000, 16'h0000, 16'hA5C3, 16'h0000, 8'd3);
        vecs[9] = mk(1'b0, 3'd0, 16'h0000, 3'd7, 3'd2, 16'hA5C3, 16'h0022, 16'hA5C3, 16'h0022, 8'd4);

        // Reset held with a write pending: the write must be discarded.
        rst_n = 1'b0;
        drive(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
            #1;
`ifdef RF_WRITE_BYPASS_EN
            check($sformatf("vec%0d_rd_a", i), bus_if.rd_data_a, vecs[i].fwd_a);
            check($sformatf("vec%0d_rd_b", i), bus_if.rd_data_b, vecs[i].fwd_b);
`else
            check($sformatf("vec%0d_rd_a", i), bus_if.rd_data_a, vecs[i].exp_a);
            check($sformatf("vec%0d_rd_b", i), bus_if.rd_data_b, vecs[i].exp_b);
`endif
            check($sformatf("vec%0d_cnt", i), {8'h00, bus_if.wr_count}, {8'h00, vecs[i].exp_cnt});
            step();
        end

        // Counter saturation: count is 4 here; 250 writes reach 254, then cap.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 3'd1, 16'(i), 3'd1, 3'd0);
            step();
            if (i == 249) begin
                check("cnt_at_254", {8'h00, bus_if.wr_count}, 16'd254);
            end
        end
        drive(1'b0, 3'd0, 16'h0000, 3'd1, 3'd1);
        #1;
        check("cnt_saturated", {8'h00, bus_if.wr_count}, 16'd255);
        check("r1_last_data", bus_if.rd_data_a, 16'd299);
        step();
        check("cnt_holds", {8'h00, bus_if.wr_count}, 16'd255);

        // Fill R1..R7, then a single-cycle reset clears everything.
        for (int r = 1; r < 8; r++) begin
            drive(1'b1, reg_addr_t'(r), 16'h0101 * 16'(r), 3'd0, 3'd0);
            step();
        end
        drive(1'b0, 3'd0, 16'h0000, 3'd7, 3'd4);
        #1;
        check("r7_before_rst", bus_if.rd_data_a, 16'h0707);
        check("r4_before_rst", bus_if.rd_data_b, 16'h0404);

        // Forwarding must be suppressed while reset is low.
        rst_n = 1'b0;
        drive(1'b1, 3'd4, 16'hFFFF, 3'd4, 3'd4);
        #1;
        check("no_fwd_in_rst", bus_if.rd_data_a, 16'h0404);
        step();
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
        #1;
        check("cnt_after_rst", {8'h00, bus_if.wr_count}, 16'd0);
        for (int r = 1; r < 8; r++) begin
            bus_if.rd_addr_a = reg_addr_t'(r);
            bus_if.rd_addr_b = reg_addr_t'(8 - r);
            #1;
            check($sformatf("r%0d_cleared_a", r), bus_if.rd_data_a, 16'h0000);
            check($sformatf("r%0d_cleared_b", 8 - r), bus_if.rd_data_b, 16'h0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_reg_file_wb

`default_nettype wire
